sync_fifo_wconv: RTL and testbench
==================================

# sync_fifo_wconv

Parametrised single-clock FIFO with a wide write port and narrow read port (integer ratio ≥1), generalising the team's single-write/multiple-read FIFO with flush, registered read data with a valid strobe, and error strobes. It sits between wide producers (frame/DMA packers) and narrow consumers (per-sample MEL datapath stages). One write word is split into RATIO read slices, LSB slice first.

## Interface
- W_WIDTH, 32, write word width; must equal RATIO*R_WIDTH.
- R_WIDTH, 16, read slice width.
- W_DEPTH, 16, capacity in write words; power of two, ≥2.
- AFULL_TH, W_DEPTH-2, almost_full threshold in write words (used only with level feature).
- AEMPTY_TH, 2, almost_empty threshold in read slices (used only with level feature).
- Derived constants: RATIO = W_WIDTH/R_WIDTH (power of two), R_DEPTH = W_DEPTH*RATIO, WA = log2(W_DEPTH), RA = log2(R_DEPTH).

- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- wr_data  in  W_WIDTH  write word.
- full  out  1  no free write word.
- wr_err  out  1  one-cycle pulse: wr_en while full.
- rd_en  in  1  read request.
- rd_data  out  R_WIDTH  registered read slice.
- rd_valid  out  1  rd_data updated this cycle.
- empty  out  1  no unread slice.
- rd_err  out  1  one-cycle pulse: rd_en while empty.

## Operation
- Storage: W_DEPTH × W_WIDTH array; read selects slice rd_ptr[log2(RATIO)-1:0] of word rd_ptr[RA-1:log2(RATIO)].
- wr_ptr: WA+1 bits; rd_ptr: RA+1 bits (extra wrap bit each). Both wrap naturally modulo 2^(bits).
- Word occupancy wocc = wr_ptr − rd_ptr[RA:log2(RATIO)] (WA+1-bit modular). A partially read word still occupies its slot.
- Slice occupancy socc = {wr_ptr, log2(RATIO) zeros} − rd_ptr (RA+1-bit modular).
- full = (wocc == W_DEPTH); empty = (socc == 0). Both combinational from registered pointers only.
- Write accepted iff wr_en & !full & !flush: mem[wr_ptr[WA-1:0]] ← wr_data, wr_ptr+1.
- Read accepted iff rd_en & !empty & !flush: rd_data ← selected slice, rd_valid ← 1, rd_ptr+1. Otherwise rd_valid ← 0, rd_data holds.
- Slice order: slice k = wr_data[(k+1)*R_WIDTH-1 : k*R_WIDTH], k = 0 first.
- RATIO = 1 degenerates to a plain synchronous FIFO; slice-select logic drops out.
- wr_err ← wr_en & full & !flush; rd_err ← rd_en & empty & !flush. Rejected requests change no state.
- flush: wr_ptr, rd_ptr ← 0, rd_valid ← 0, rd_data holds; has priority over same-cycle wr_en/rd_en.

## Timing
- Reset values: wr_ptr=rd_ptr=0, empty=1, full=0, rd_valid=0, rd_data=0, wr_err=0, rd_err=0. Memory not reset.
- Write at edge N → empty deasserts after edge N; earliest read accept at edge N+1.
- Read latency 1: rd_en accepted at edge N → rd_data/rd_valid valid after edge N, for one cycle.
- Simultaneous read and write: both evaluated against pre-edge flags. Full + rd_en + wr_en: write rejected (wr_err), read accepted. Empty + both: read rejected (rd_err), write accepted.
- full deasserts only after the last slice of the oldest word is read.
- Reset mid-operation: all state returns to reset values immediately; no output glitch beyond reset assertion.
- Back-to-back reads sustain one slice per cycle across word and pointer-wrap boundaries.

## Configuration
- SYNC_FIFO_WCONV_LEVEL_EN defined: adds outputs wr_level (WA+1 bits, = wocc), rd_level (RA+1 bits, = socc), almost_full (wocc ≥ AFULL_TH), almost_empty (socc ≤ AEMPTY_TH); all combinational from pointers; reset values 0, 0, 0, 1.
- Not defined: these ports and logic are absent; AFULL_TH/AEMPTY_TH ignored.

## Structure
- Shared package mel_fifo_pkg: clog2-based ratio/address-width helper functions, pointer-difference function, elaboration check that W_WIDTH % R_WIDTH == 0 and RATIO, W_DEPTH are powers of two.
- One sub-module: sync_fifo_wconv_mem, simple dual-port RAM (W_WIDTH write, W_WIDTH registered-address-free async read), so technology RAMs can be swapped in.

## Test plan
- Reset, W=32/R=16/W_DEPTH=4: after rst_n release empty=1, full=0, rd_valid=0, rd_data=0.
- Write 0xBBBB_AAAA, then rd_en two cycles → rd_data 0xAAAA then 0xBBBB, rd_valid high two cycles, empty=1 after.
- Write 4 words → full=1; extra write → wr_err pulse, contents unchanged; read one slice → full stays 1; read second slice → full=0.
- Full, wr_en+rd_en same cycle → read accepted, write rejected; empty, both → write accepted, rd_err pulse, empty=0 next cycle.
- Stream 20 words continuously with rd_en held: 40 slices in order, pointer wrap verified, no errors.
- Mid-stream flush with wr_en/rd_en high → next cycle empty=1, rd_valid=0; with LEVEL_EN, wr_level=rd_level=0, almost_empty=1.

Source files
------------

// File: rtl/mel_fifo_pkg.sv
// Shared helpers for the MEL width-converting FIFOs: address/ratio sizing,
// configuration legality and modular pointer distance.
`timescale 1ns/1ps
package mel_fifo_pkg;

    function automatic int unsigned log2c(input int unsigned v);
        return $clog2(v);
    endfunction

    function automatic int unsigned ratio_of(input int unsigned w_width, input int unsigned r_width);
        return w_width / r_width;
    endfunction

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit cfg_ok(input int unsigned w_width, input int unsigned r_width,
                                  input int unsigned w_depth);
        return (r_width != 0) && (w_width % r_width == 0) &&
               is_pow2(w_width / r_width) && is_pow2(w_depth) && (w_depth >= 2);
    endfunction

    // Distance a - b taken modulo 2**bits; upper result bits are zero.
    function automatic logic [31:0] ptr_diff(input logic [31:0] a, input logic [31:0] b,
                                             input int unsigned bits);
        logic [31:0] mask;
        mask = (bits >= 32) ? '1 : ((32'd1 << bits) - 32'd1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/sync_fifo_wconv_mem.sv
// Simple dual-port word store: synchronous write, asynchronous read.
// Kept separate so a technology RAM can replace the inferred array.
`timescale 1ns/1ps
module sync_fifo_wconv_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_wconv.sv
// Wide-write / narrow-read FIFO: each write word leaves as RATIO slices, LSB first.
// Optional occupancy outputs when SYNC_FIFO_WCONV_LEVEL_EN is defined.
`timescale 1ns/1ps
module sync_fifo_wconv
    import mel_fifo_pkg::*;
#(
    parameter int W_WIDTH   = 32,
    parameter int R_WIDTH   = 16,
    parameter int W_DEPTH   = 16,
    parameter int AFULL_TH  = W_DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      flush,
    input  logic                                      wr_en,
    input  logic [W_WIDTH-1:0]                        wr_data,
    output logic                                      full,
    output logic                                      wr_err,
    input  logic                                      rd_en,
    output logic [R_WIDTH-1:0]                        rd_data,
    output logic                                      rd_valid,
    output logic                                      empty,
`ifdef SYNC_FIFO_WCONV_LEVEL_EN
    output logic [$clog2(W_DEPTH):0]                  wr_level,
    output logic [$clog2(W_DEPTH*(W_WIDTH/R_WIDTH)):0] rd_level,
    output logic                                      almost_full,
    output logic                                      almost_empty,
`endif
    output logic                                      rd_err
);

    localparam int RATIO   = ratio_of(W_WIDTH, R_WIDTH);
    localparam int R_DEPTH = W_DEPTH * RATIO;
    localparam int WA      = log2c(W_DEPTH);
    localparam int RB      = log2c(RATIO);
    localparam int RA      = log2c(R_DEPTH);

    if (!cfg_ok(W_WIDTH, R_WIDTH, W_DEPTH)) begin : g_cfg_err
        $error("sync_fifo_wconv: illegal W_WIDTH/R_WIDTH/W_DEPTH combination");
    end

    logic [WA:0]          wr_ptr;
    logic [RA:0]          rd_ptr;
    logic [WA:0]          rd_wptr;
    logic [WA:0]          wocc;
    logic [RA:0]          socc;
    logic [31:0]          wocc_raw;
    logic [31:0]          socc_raw;
    logic                 unused_hi;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [W_WIDTH-1:0]   rd_word;
    logic [R_WIDTH-1:0]   rd_slice;

    // A partly read word still owns its slot: word occupancy uses the word part of rd_ptr.
    assign rd_wptr   = rd_ptr[RA:RB];
    assign wocc_raw  = ptr_diff(32'(wr_ptr), 32'(rd_wptr), WA + 1);
    assign socc_raw  = ptr_diff(32'(wr_ptr) << RB, 32'(rd_ptr), RA + 1);
    assign wocc      = wocc_raw[WA:0];
    assign socc      = socc_raw[RA:0];
    assign unused_hi = ^{wocc_raw[31:WA+1], socc_raw[31:RA+1]};

    assign full   = (wocc == (WA+1)'(W_DEPTH));
    assign empty  = (socc == '0);
    assign wr_acc = wr_en & ~full & ~flush;
    assign rd_acc = rd_en & ~empty & ~flush;

    sync_fifo_wconv_mem #(
        .WIDTH (W_WIDTH),
        .DEPTH (W_DEPTH),
        .AW    (WA)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr[WA-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[RA-1:RB]),
        .rd_data (rd_word)
    );

    if (RATIO == 1) begin : g_noslice
        assign rd_slice = rd_word;
    end else begin : g_slice
        assign rd_slice = rd_word[rd_ptr[RB-1:0]*R_WIDTH +: R_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
            rd_err   <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            wr_err   <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= rd_slice;
            end
            rd_valid <= rd_acc;
            wr_err   <= wr_en & full;
            rd_err   <= rd_en & empty;
        end
    end

`ifdef SYNC_FIFO_WCONV_LEVEL_EN
    assign wr_level     = wocc;
    assign rd_level     = socc;
    assign almost_full  = (int'(wocc) >= AFULL_TH);
    assign almost_empty = (int'(socc) <= AEMPTY_TH);
`endif

endmodule

// File: tb/tb_sync_fifo_wconv.sv
// Directed bench for sync_fifo_wconv at 32->16 bits, 4 words deep.
`timescale 1ns/1ps
module tb_sync_fifo_wconv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        full;
    logic        wr_err;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        rd_err;
`ifdef SYNC_FIFO_WCONV_LEVEL_EN
    logic [2:0]  wr_level;
    logic [3:0]  rd_level;
    logic        almost_full;
    logic        almost_empty;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_fifo_wconv #(
        .W_WIDTH (32),
        .R_WIDTH (16),
        .W_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .wr_err       (wr_err),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
`ifdef SYNC_FIFO_WCONV_LEVEL_EN
        .wr_level     (wr_level),
        .rd_level     (rd_level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .rd_err       (rd_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++; if (empty !== 1'b1)    begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0)     begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
        checks++; if (wr_err !== 1'b0 || rd_err !== 1'b0)
            begin errors++; $display("FAIL reset_err got=%b%b exp=00", wr_err, rd_err); end
`ifdef SYNC_FIFO_WCONV_LEVEL_EN
        checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0 || wr_level !== 3'd0 || rd_level !== 4'd0)
            begin errors++; $display("FAIL reset_level got=%b%b %0d %0d exp=10 0 0", almost_empty, almost_full, wr_level, rd_level); end
`endif
    endtask

    task automatic test_single_word();
        wr_en = 1'b1; wr_data = 32'hBBBB_AAAA;
        step();
        wr_en = 1'b0;
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_not_empty got=%b exp=0", empty); end
        rd_en = 1'b1;
        step();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hAAAA)
            begin errors++; $display("FAIL single_slice0 got=%b/%h exp=1/aaaa", rd_valid, rd_data); end
        step();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'hBBBB)
            begin errors++; $display("FAIL single_slice1 got=%b/%h exp=1/bbbb", rd_valid, rd_data); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after got=%b exp=1", empty); end
        step();
        checks++; if (rd_valid !== 1'b0 || rd_err !== 1'b0)
            begin errors++; $display("FAIL single_idle got=%b/%b exp=0/0", rd_valid, rd_err); end
    endtask

    task automatic fill4(input logic [15:0] base);
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = {16'(base + 16'(2*i+1)), 16'(base + 16'(2*i))};
            step();
        end
        wr_en = 1'b0;
    endtask

    task automatic test_full();
        fill4(16'h1000);
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_set got=%b exp=1", full); end
`ifdef SYNC_FIFO_WCONV_LEVEL_EN
        checks++; if (wr_level !== 3'd4 || rd_level !== 4'd8 || almost_full !== 1'b1 || almost_empty !== 1'b0)
            begin errors++; $display("FAIL full_level got=%0d %0d %b%b exp=4 8 10", wr_level, rd_level, almost_full, almost_empty); end
`endif
        wr_en = 1'b1; wr_data = 32'hDEAD_BEEF;
        step();
        wr_en = 1'b0;
        checks++; if (wr_err !== 1'b1 || full !== 1'b1)
            begin errors++; $display("FAIL full_wr_err got=%b/%b exp=1/1", wr_err, full); end
        rd_en = 1'b1;
        step();
        checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL full_wr_err_pulse got=%b exp=0", wr_err); end
        checks++; if (rd_data !== 16'h1000 || full !== 1'b1)
            begin errors++; $display("FAIL full_half_read got=%h/%b exp=1000/1", rd_data, full); end
        step();
        checks++; if (rd_data !== 16'h1001 || full !== 1'b0)
            begin errors++; $display("FAIL full_release got=%h/%b exp=1001/0", rd_data, full); end
        for (int j = 2; j < 8; j++) begin
            step();
            checks++; if (rd_valid !== 1'b1 || rd_data !== 16'(16'h1000 + j))
                begin errors++; $display("FAIL full_drain%0d got=%b/%h exp=1/%h", j, rd_valid, rd_data, 16'(16'h1000 + j)); end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained got=%b exp=1", empty); end
    endtask

    task automatic test_simultaneous();
        fill4(16'h2000);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'hCAFE_F00D;
        step();
        wr_en = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 16'h2000 || wr_err !== 1'b1)
            begin errors++; $display("FAIL simul_full got=%b/%h/%b exp=1/2000/1", rd_valid, rd_data, wr_err); end
        for (int j = 1; j < 8; j++) begin
            step();
            checks++; if (rd_data !== 16'(16'h2000 + j))
                begin errors++; $display("FAIL simul_drain%0d got=%h exp=%h", j, rd_data, 16'(16'h2000 + j)); end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_drained got=%b exp=1", empty); end
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 32'h3001_3000;
        step();
        wr_en = 1'b0;
        checks++; if (rd_err !== 1'b1 || rd_valid !== 1'b0 || empty !== 1'b0)
            begin errors++; $display("FAIL simul_empty got=%b/%b/%b exp=1/0/0", rd_err, rd_valid, empty); end
        step();
        checks++; if (rd_data !== 16'h3000 || rd_err !== 1'b0)
            begin errors++; $display("FAIL simul_read0 got=%h/%b exp=3000/0", rd_data, rd_err); end
        step();
        rd_en = 1'b0;
        checks++; if (rd_data !== 16'h3001 || empty !== 1'b1)
            begin errors++; $display("FAIL simul_read1 got=%h/%b exp=3001/1", rd_data, empty); end
    endtask

    task automatic test_back_to_back();
        int  wcnt = 0;
        int  rcnt = 0;
        int  cyc  = 0;
        bit  wacc;
        bit  racc;
        wr_en = 1'b1; wr_data = {16'h4001, 16'h4000}; rd_en = 1'b0;
        while ((wcnt < 20 || rcnt < 40) && cyc < 300) begin
            wacc = wr_en && !full;
            racc = rd_en && !empty;
            step();
            cyc++;
            if (wacc) wcnt++;
            checks++; if (rd_valid !== racc)
                begin errors++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, rd_valid, racc); end
            if (racc) begin
                checks++; if (rd_data !== 16'(16'h4000 + rcnt))
                    begin errors++; $display("FAIL stream_data%0d got=%h exp=%h", rcnt, rd_data, 16'(16'h4000 + rcnt)); end
                rcnt++;
            end
            checks++; if (wr_err !== 1'b0 || rd_err !== 1'b0)
                begin errors++; $display("FAIL stream_err cyc=%0d got=%b%b exp=00", cyc, wr_err, rd_err); end
            wr_en   = (wcnt < 20) && !full;
            wr_data = {16'(16'h4001 + 16'(2*wcnt)), 16'(16'h4000 + 16'(2*wcnt))};
            rd_en   = (rcnt < 40) && (wcnt > 0);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (cyc >= 300) begin errors++; $display("FAIL stream_timeout got=%0d slices exp=40", rcnt); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty got=%b exp=1", empty); end
    endtask

    task automatic test_flush();
        wr_en = 1'b1; wr_data = 32'h6001_6000;
        step();
        wr_data = 32'h6003_6002; rd_en = 1'b1;
        step();
        wr_data = 32'h6005_6004; flush = 1'b1;
        step();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        checks++; if (empty !== 1'b1 || rd_valid !== 1'b0)
            begin errors++; $display("FAIL flush_state got=%b/%b exp=1/0", empty, rd_valid); end
        checks++; if (rd_data !== 16'h6000) begin errors++; $display("FAIL flush_hold got=%h exp=6000", rd_data); end
        checks++; if (wr_err !== 1'b0 || rd_err !== 1'b0 || full !== 1'b0)
            begin errors++; $display("FAIL flush_flags got=%b%b%b exp=000", wr_err, rd_err, full); end
`ifdef SYNC_FIFO_WCONV_LEVEL_EN
        checks++; if (wr_level !== 3'd0 || rd_level !== 4'd0 || almost_empty !== 1'b1)
            begin errors++; $display("FAIL flush_level got=%0d %0d %b exp=0 0 1", wr_level, rd_level, almost_empty); end
`endif
        wr_en = 1'b1; wr_data = 32'h7001_7000;
        step();
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (rd_data !== 16'h7000 || empty !== 1'b0)
            begin errors++; $display("FAIL flush_restart got=%h/%b exp=7000/0", rd_data, empty); end
    endtask

    task automatic test_reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || rd_data !== 16'h0 || rd_valid !== 1'b0)
            begin errors++; $display("FAIL mid_reset got=%b/%h/%b exp=1/0000/0", empty, rd_data, rd_valid); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (empty !== 1'b1 || full !== 1'b0)
            begin errors++; $display("FAIL mid_reset_release got=%b/%b exp=1/0", empty, full); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full();
        test_simultaneous();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
